// File: rtl/dut_vector_sequencer.sv
// dut_vector_sequencer
// Drives a combinational dut one vector at a time. Each vector arrives on a
// valid/ready stream and is applied to the dut. After SETTLE cycles the dut
// response is captured and optionally compared with an expected value. The
// captured result is returned on a second valid/ready stream, and pass/fail
// counters record the outcome of checked vectors.
//
// Parameters: IN_W (dut input width), OUT_W (dut output width),
//             SETTLE (apply-to-capture cycles, 1..255), CNT_W (counter width)
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   vec_valid/vec_ready/vec_data/
//   vec_exp/vec_chk                   stimulus stream
//   dut_in / dut_out                  dut stimulus and response
//   res_valid/res_ready/res_data/
//   res_mismatch                      result stream
//   pass_cnt, fail_cnt, cnt_clr       saturating outcome counters and clear
//   busy                              a vector is in flight
//
// state  | meaning
// IDLE   | waiting for a vector; vec_ready high (except first cycle of reset)
// WAIT   | vector applied to dut, counting down the settle interval
// HOLD   | result presented, waiting for the consumer to take it
module dut_vector_sequencer #(
  parameter int IN_W   = 50,
  parameter int OUT_W  = 30,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_data,
  input  logic [OUT_W-1:0] vec_exp,
  input  logic             vec_chk,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic             res_mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  input  logic             cnt_clr,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  localparam logic [7:0]       SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       settle_q, settle_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic [OUT_W-1:0] exp_q, exp_d;
  logic             chk_q, chk_d;
  logic [OUT_W-1:0] res_data_q, res_data_d;
  logic             res_mis_q, res_mis_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  // Registered so vec_ready stays low through reset yet has no
  // combinational path from any input.
  logic             vec_ready_q;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    dut_in_d    = dut_in_q;
    exp_d       = exp_q;
    chk_d       = chk_q;
    res_data_d  = res_data_q;
    res_mis_d   = res_mis_q;
    res_valid_d = res_valid_q;
    pass_d      = pass_q;
    fail_d      = fail_q;

    case (state_q)
      S_IDLE: begin
        if (vec_valid && vec_ready_q) begin
          dut_in_d = vec_data;
          exp_d    = vec_exp;
          chk_d    = vec_chk;
          settle_d = SETTLE_M1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (settle_q != 8'd0) begin
          settle_d = settle_q - 8'd1;
        end else begin
          res_data_d  = dut_out;
          res_mis_d   = chk_q && (dut_out != exp_q);
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
          if (chk_q) begin
            if (dut_out == exp_q) begin
              if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
            end else begin
              if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
            end
          end
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear takes priority over a same-cycle increment.
    if (cnt_clr) begin
      pass_d = '0;
      fail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      settle_q    <= 8'd0;
      dut_in_q    <= '0;
      exp_q       <= '0;
      chk_q       <= 1'b0;
      res_data_q  <= '0;
      res_mis_q   <= 1'b0;
      res_valid_q <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      vec_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      dut_in_q    <= dut_in_d;
      exp_q       <= exp_d;
      chk_q       <= chk_d;
      res_data_q  <= res_data_d;
      res_mis_q   <= res_mis_d;
      res_valid_q <= res_valid_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      vec_ready_q <= (state_d == S_IDLE);
    end
  end

  assign vec_ready    = vec_ready_q;
  assign busy         = (state_q != S_IDLE);
  assign dut_in       = dut_in_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_mismatch = res_mis_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;

endmodule

// File: doc/dut_vector_sequencer.md
# dut_vector_sequencer

Clocked harness controller that drives the combinational `dut` (50-bit `in`, 30-bit `out`) one test vector at a time. It accepts stimulus vectors on a valid/ready stream and applies each one to the dut. After a fixed settle interval it captures the response, compares it against an optional expected value, and returns the captured result on a second valid/ready stream. It sits between the vector source (memory or host model) and the dut, replacing the one-shot `$readmemb` testbench flow with a sequenced, self-checking stream.

## Interface
- `IN_W`, 50, dut input width
- `OUT_W`, 30, dut output width
- `SETTLE`, 1, cycles between applying a vector and capturing dut output; legal range 1..255
- `CNT_W`, 16, width of the pass/fail counters
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `vec_valid`  in  1  stimulus vector present
- `vec_ready`  out  1  sequencer can accept a vector
- `vec_data`  in  IN_W  stimulus for dut `in`
- `vec_exp`  in  OUT_W  expected dut `out`
- `vec_chk`  in  1  1 = compare against `vec_exp`; 0 = capture only
- `dut_in`  out  IN_W  drives dut `in`
- `dut_out`  in  OUT_W  from dut `out`
- `res_valid`  out  1  result present
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  OUT_W  captured dut output
- `res_mismatch`  out  1  `vec_chk` was set and `res_data != vec_exp`
- `pass_cnt`  out  CNT_W  checked vectors that matched
- `fail_cnt`  out  CNT_W  checked vectors that mismatched
- `cnt_clr`  in  1  synchronous clear of both counters
- `busy`  out  1  state != IDLE

## Operation
- FSM states are IDLE, WAIT, HOLD.
- **IDLE**
  - `vec_ready`=1.
  - On `vec_valid & vec_ready`: register `dut_in<=vec_data`, latch `vec_exp`/`vec_chk`, load `settle_cnt<=SETTLE-1`, go to WAIT.
- **WAIT**
  - `dut_in` is held and `vec_ready`=0.
  - While `settle_cnt!=0`, decrement it.
  - When `settle_cnt==0`:
    - capture `res_data<=dut_out`;
    - set `res_mismatch<=chk & (dut_out!=exp)`;
    - update the counters;
    - set `res_valid<=1` and go to HOLD.
- **HOLD**
  - `res_data`/`res_mismatch` are held stable while `res_valid & !res_ready`.
  - On `res_valid & res_ready`: `res_valid<=0`, go to IDLE.
- `dut_in` keeps the last applied vector after the result is accepted. It changes only on a new vector handshake or on reset.
- Counters:
  - `pass_cnt` increments on a checked match.
  - `fail_cnt` increments on a checked mismatch.
  - Unchecked vectors increment neither counter.
  - Both counters saturate at all-ones and do not wrap.
- If `cnt_clr` coincides with an increment, the clear wins and the counter becomes 0.
- Only one vector is in flight at a time. No vector is accepted in WAIT or HOLD.

## Timing
- Reset values:
  - state = IDLE;
  - `dut_in`=0, `res_data`=0, `res_mismatch`=0, `res_valid`=0;
  - `pass_cnt`=0, `fail_cnt`=0, `busy`=0;
  - `vec_ready`=1 in the first cycle after reset deasserts and 0 while `rst` is high.
- Reset mid-operation (WAIT or HOLD) aborts the vector. No result is emitted and the counters are cleared.
- Vector handshake at edge k:
  - `dut_in` is valid after edge k;
  - capture happens at edge k+SETTLE;
  - `res_valid` is high from edge k+SETTLE.
- With `res_ready` tied high, the result is accepted at edge k+SETTLE+1 and the next vector at k+SETTLE+2. Maximum throughput is one vector per SETTLE+2 cycles.
- `vec_ready`, `busy` and `res_valid` are decoded from registered state only, with no combinational path from inputs.
- Counters update at the capture edge and are visible from cycle k+SETTLE.

## Test plan
- **Reset then zero vector:** `rst` then `vec_data`=0, `vec_exp`=30'h2554BA58, `vec_chk`=1, SETTLE=1 → `res_valid` two edges after reset release plus handshake; `res_data`=30'h2554BA58, `res_mismatch`=0, `pass_cnt`=1.
- **Known mismatch:** `vec_data`=50'h8 (in[3]=1), `vec_exp`=30'h2554BA58 → `res_data`=30'h2554BA50, `res_mismatch`=1, `fail_cnt`=1, `pass_cnt` unchanged.
- **Backpressure:** `res_ready`=0 for 5 cycles after `res_valid` → `res_data` stable, `vec_ready`=0 throughout, `vec_valid` ignored; accept on cycle 6 → `vec_ready`=1 the next cycle.
- **Back-to-back with SETTLE=3 and `res_ready`=1:** 4 vectors presented continuously → accepts at k, k+5, k+10, k+15; `dut_in` changes only at those edges.
- **Reset in WAIT:** assert `rst` one cycle after a handshake → no `res_valid`, all counters 0, `dut_in`=0, `vec_ready`=1 after release.
- **Saturation and clear with CNT_W=2:** 5 matching checked vectors → `pass_cnt`=3; `cnt_clr` asserted on the capture edge of a 6th match → `pass_cnt`=0.
